// File: rtl/contador_udm_p.sv
// contador_udm_p -- parametrised up/down counter with modulus, step size,
// wrap/saturate mode, synchronous load and count-enable.
//
// Optional feature (macro CONTADOR_UDM_EDGE_EN):
//   defined   -> up/down are edge-qualified: a step happens only on a rising
//                edge of the request, so a held push-button counts once.
//   undefined -> up/down are level-sensitive: one step per enabled clock.
//
// Per-cycle priority: reset > load > single-direction enabled step > hold.
// Requests for both directions in the same cycle mean hold: no pulses, and
// ovf keeps its value.
//
// carry/borrow are registered and are high exactly in the cycle the wrapped
// count is visible. That lets a chain of digits connect carry of digit n to
// en of digit n+1, with up tied high on digit n+1.
module contador_udm_p #(
    parameter int W    = 4,
    parameter int MOD  = 10,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         down,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         sat,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         at_min,
    output logic         carry,
    output logic         borrow,
    output logic         ovf
);

    // Limits and step, in count width and in the W+1 bit arithmetic width.
    // The extra bit keeps count+STEP and count+MOD from overflowing when MOD
    // reaches 2^W.
    localparam logic [W-1:0] MAX_W  = W'(MOD - 1);
    localparam logic [W:0]   MAX_X  = (W+1)'(MOD - 1);
    localparam logic [W:0]   MOD_X  = (W+1)'(MOD);
    localparam logic [W:0]   STEP_X = (W+1)'(STEP);

    // State registers and their next-state values
    logic [W-1:0] count_q,  count_d;
    logic         carry_q,  carry_d;
    logic         borrow_q, borrow_d;
    logic         ovf_q,    ovf_d;

    // Qualified direction requests
    logic up_req;
    logic down_req;
    logic step_up;
    logic step_dn;

    // Arithmetic intermediates, all W+1 bits wide
    logic [W:0] count_x;
    logic [W:0] sum_x;
    logic [W:0] diff_x;
    logic [W:0] up_wrap_x;
    logic [W:0] dn_wrap_x;

`ifdef CONTADOR_UDM_EDGE_EN
    logic prev_up_q;
    logic prev_down_q;

    // Remember last cycle's requests; this runs whether or not en is high,
    // so a button held while disabled does not step when en returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_up_q   <= 1'b0;
            prev_down_q <= 1'b0;
        end else begin
            prev_up_q   <= up;
            prev_down_q <= down;
        end
    end

    assign up_req   = up   & ~prev_up_q;
    assign down_req = down & ~prev_down_q;
`else
    assign up_req   = up;
    assign down_req = down;
`endif

    // Both directions together, or neither, is a hold
    assign step_up = en & up_req   & ~down_req;
    assign step_dn = en & down_req & ~up_req;

    // Candidate results for every step outcome
    assign count_x   = {1'b0, count_q};
    assign sum_x     = count_x + STEP_X;
    assign diff_x    = count_x - STEP_X;
    assign up_wrap_x = sum_x - MOD_X;
    assign dn_wrap_x = count_x + MOD_X - STEP_X;

    // Next-state selection following the per-cycle priority
    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        ovf_d    = ovf_q;

        if (load) begin
            // Out-of-range load values clamp to the top of the range
            if (load_val > MAX_W) begin
                count_d = MAX_W;
            end else begin
                count_d = load_val;
            end
            ovf_d = 1'b0;
        end else if (step_up) begin
            if (sum_x <= MAX_X) begin
                count_d = W'(sum_x);
            end else begin
                // Passing the top either wraps or clips; both set ovf
                ovf_d = 1'b1;
                if (sat) begin
                    count_d = MAX_W;
                end else begin
                    count_d = W'(up_wrap_x);
                    carry_d = 1'b1;
                end
            end
        end else if (step_dn) begin
            if (count_x >= STEP_X) begin
                count_d = W'(diff_x);
            end else begin
                // Passing zero either wraps or clips; both set ovf
                ovf_d = 1'b1;
                if (sat) begin
                    count_d = '0;
                end else begin
                    count_d  = W'(dn_wrap_x);
                    borrow_d = 1'b1;
                end
            end
        end
    end

    // Counter and flag registers; reset beats everything
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    // Outputs: limit flags decode the count register with no extra delay
    assign count  = count_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;
    assign at_max = (count_q == MAX_W);
    assign at_min = (count_q == '0);

endmodule
